// File: rtl/nn_output_scorer_if.sv
// Signal bundle between the MAC/control sequencer and the output-layer scorer.
// The sequencer drives through the master modport; the scorer uses slave.
interface nn_output_scorer_if;
  logic               rst_Acc;
  logic               ld_Acc;
  logic signed [15:0] acc_in;
  logic               ld_val;
  logic        [3:0]  neuron_idx;
  logic               t;
  logic        [3:0]  label;
  logic               ld_Cor;
  logic               rst_Cor;
  logic signed [23:0] acc_out;
  logic        [3:0]  pred;
  logic               pred_valid;
  logic        [15:0] correct_cnt;
  logic        [15:0] sample_cnt;
  logic               err;

  modport master (
    output rst_Acc, ld_Acc, acc_in, ld_val, neuron_idx, t, label, ld_Cor, rst_Cor,
    input  acc_out, pred, pred_valid, correct_cnt, sample_cnt, err
  );

  modport slave (
    input  rst_Acc, ld_Acc, acc_in, ld_val, neuron_idx, t, label, ld_Cor, rst_Cor,
    output acc_out, pred, pred_valid, correct_cnt, sample_cnt, err
  );
endinterface

// File: rtl/nn_output_scorer.sv
// Output-layer scorer: saturating neuron accumulator, argmax scan over up to
// ten output neurons, and saturating correct/sample counters.
module nn_output_scorer #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  nn_output_scorer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  localparam logic [3:0] LAST_IDX = 4'd9;

  logic signed [ACC_W-1:0] acc_p0;
  logic signed [ACC_W:0]   acc_sum;

  state_t                  state;
  state_t                  state_mid;
  logic signed [ACC_W-1:0] best_val;
  logic        [3:0]       best_idx;
  logic signed [ACC_W-1:0] next_val;
  logic        [3:0]       next_idx;
  logic        [3:0]       pred;
  logic                    pred_valid;
  logic                    err;
  logic        [CNT_W-1:0] correct_cnt;
  logic        [CNT_W-1:0] sample_cnt;
  logic                    cor_hit;
  logic                    cor_err;
  logic                    val_bad;

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] s);
    logic signed [ACC_W-1:0] r;
    if (s[ACC_W] != s[ACC_W-1])
      r = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      r = s[ACC_W-1:0];
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Stage p0: accumulator, one extra bit of headroom before saturation
  assign acc_sum = {acc_p0[ACC_W-1], acc_p0}
                 + {{(ACC_W+1-DATA_W){bus.acc_in[DATA_W-1]}}, bus.acc_in};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      acc_p0 <= '0;
    else if (bus.rst_Acc)
      acc_p0 <= '0;
    else if (bus.ld_Acc)
      acc_p0 <= sat_acc(acc_sum);
  end

  // Scoring is resolved before ld_val so a same-cycle ld_val sees the post-score state
  assign cor_hit = bus.ld_Cor && (state == HOLD);
  assign cor_err = bus.ld_Cor && (state != HOLD);

  always_comb begin
    state_mid = state;
    if (cor_hit)
      state_mid = IDLE;
  end

  assign val_bad = bus.ld_val &&
                   ((bus.neuron_idx > LAST_IDX) ||
                    ((bus.neuron_idx != 4'd0) && (state_mid != SCAN)));

  always_comb begin
    next_val = best_val;
    next_idx = best_idx;
    if (acc_p0 > best_val) begin
      next_val = acc_p0;
      next_idx = bus.neuron_idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      best_val    <= '0;
      best_idx    <= '0;
      pred        <= '0;
      pred_valid  <= 1'b0;
      err         <= 1'b0;
      correct_cnt <= '0;
      sample_cnt  <= '0;
    end else begin
      pred_valid <= 1'b0;
      err        <= cor_err | val_bad;
      state      <= state_mid;

      if (bus.rst_Cor) begin
        correct_cnt <= '0;
        sample_cnt  <= '0;
      end else if (cor_hit) begin
        sample_cnt <= sat_inc(sample_cnt);
        if (pred == bus.label)
          correct_cnt <= sat_inc(correct_cnt);
      end

      if (bus.ld_val && !val_bad) begin
        if (bus.neuron_idx == 4'd0) begin
          best_val <= acc_p0;
          best_idx <= 4'd0;
          if (bus.t) begin
            pred       <= 4'd0;
            pred_valid <= 1'b1;
            state      <= HOLD;
          end else begin
            state <= SCAN;
          end
        end else begin
          best_val <= next_val;
          best_idx <= next_idx;
          if (bus.t) begin
            pred       <= next_idx;
            pred_valid <= 1'b1;
            state      <= HOLD;
          end
        end
      end
    end
  end

  assign bus.acc_out     = acc_p0;
  assign bus.pred        = pred;
  assign bus.pred_valid  = pred_valid;
  assign bus.err         = err;
  assign bus.correct_cnt = correct_cnt;
  assign bus.sample_cnt  = sample_cnt;

endmodule

// File: tb/tb_nn_output_scorer.sv
// Directed bench for nn_output_scorer: accumulation, argmax, scoring,
// protocol errors and asynchronous reset, with hand-computed expectations.
module tb_nn_output_scorer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  nn_output_scorer_if bus();

  nn_output_scorer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_ctl();
    bus.rst_Acc = 1'b0;
    bus.ld_Acc  = 1'b0;
    bus.ld_val  = 1'b0;
    bus.t       = 1'b0;
    bus.ld_Cor  = 1'b0;
    bus.rst_Cor = 1'b0;
  endtask

  // One clock edge with the currently driven inputs; outputs settle 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
    clear_ctl();
  endtask

  task automatic set_acc(input int v);
    bus.rst_Acc = 1'b1;
    step();
    bus.ld_Acc = 1'b1;
    bus.acc_in = 16'(v);
    step();
  endtask

  task automatic ldval(input int idx, input bit last);
    bus.ld_val     = 1'b1;
    bus.neuron_idx = 4'(idx);
    bus.t          = last;
    step();
  endtask

  task automatic score(input int lbl);
    bus.ld_Cor = 1'b1;
    bus.label  = 4'(lbl);
    step();
  endtask

  int vals_a [10] = '{5, -2, 40, 40, 3, 0, 0, 0, 0, 12};
  int vals_b [10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 50};

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    clear_ctl();
    bus.acc_in     = '0;
    bus.neuron_idx = '0;
    bus.label      = '0;

    #3;
    check_eq("reset acc_out", int'(bus.acc_out), 0);
    check_eq("reset pred", int'(bus.pred), 0);
    check_eq("reset pred_valid", int'(bus.pred_valid), 0);
    check_eq("reset err", int'(bus.err), 0);
    check_eq("reset correct_cnt", int'(bus.correct_cnt), 0);
    check_eq("reset sample_cnt", int'(bus.sample_cnt), 0);
    @(negedge clk);
    rst = 1'b1;

    // Accumulation and saturation
    bus.rst_Acc = 1'b1;
    step();
    check_eq("acc cleared", int'(bus.acc_out), 0);
    bus.ld_Acc = 1'b1; bus.acc_in = 16'sd100; step();
    bus.ld_Acc = 1'b1; bus.acc_in = -16'sd30; step();
    bus.ld_Acc = 1'b1; bus.acc_in = 16'sd7;   step();
    check_eq("acc 100-30+7", int'(bus.acc_out), 77);
    for (int i = 0; i < 200; i++) begin
      bus.ld_Acc = 1'b1; bus.acc_in = 16'sd32767; step();
    end
    check_eq("acc 77+200*32767", int'(bus.acc_out), 6553477);
    for (int i = 0; i < 100; i++) begin
      bus.ld_Acc = 1'b1; bus.acc_in = 16'sd32767; step();
    end
    check_eq("acc pos saturate", int'(bus.acc_out), 8388607);
    bus.rst_Acc = 1'b1; bus.ld_Acc = 1'b1; bus.acc_in = 16'sd5; step();
    check_eq("rst_Acc over ld_Acc", int'(bus.acc_out), 0);
    for (int i = 0; i < 300; i++) begin
      bus.ld_Acc = 1'b1; bus.acc_in = -16'sd32768; step();
    end
    check_eq("acc neg saturate", int'(bus.acc_out), -8388608);

    // Argmax with a tie between idx 2 and 3
    for (int i = 0; i < 10; i++) begin
      set_acc(vals_a[i]);
      ldval(i, i == 9);
    end
    check_eq("argmax pred", int'(bus.pred), 2);
    check_eq("argmax pred_valid", int'(bus.pred_valid), 1);
    step();
    check_eq("pred_valid one cycle", int'(bus.pred_valid), 0);
    check_eq("pred held", int'(bus.pred), 2);

    // Scoring
    score(2);
    check_eq("score1 correct", int'(bus.correct_cnt), 1);
    check_eq("score1 samples", int'(bus.sample_cnt), 1);
    check_eq("score1 err", int'(bus.err), 0);
    for (int i = 0; i < 10; i++) begin
      set_acc(vals_b[i]);
      ldval(i, i == 9);
    end
    check_eq("sample2 pred", int'(bus.pred), 9);
    score(4);
    check_eq("score2 correct", int'(bus.correct_cnt), 1);
    check_eq("score2 samples", int'(bus.sample_cnt), 2);
    score(9);
    check_eq("ld_Cor idle err", int'(bus.err), 1);
    check_eq("ld_Cor idle correct", int'(bus.correct_cnt), 1);
    check_eq("ld_Cor idle samples", int'(bus.sample_cnt), 2);
    step();
    check_eq("err one cycle", int'(bus.err), 0);

    // Protocol errors
    ldval(3, 1'b0);
    check_eq("idx3 idle err", int'(bus.err), 1);
    check_eq("idx3 idle pred", int'(bus.pred), 9);
    ldval(12, 1'b0);
    check_eq("idx12 err", int'(bus.err), 1);
    check_eq("idx12 pred", int'(bus.pred), 9);

    // Asynchronous reset mid-scan
    for (int i = 0; i < 5; i++) begin
      set_acc(10 * (i + 1));
      ldval(i, 1'b0);
    end
    #2;
    rst = 1'b0;
    #1;
    check_eq("async acc_out", int'(bus.acc_out), 0);
    check_eq("async pred", int'(bus.pred), 0);
    check_eq("async correct", int'(bus.correct_cnt), 0);
    check_eq("async samples", int'(bus.sample_cnt), 0);
    check_eq("async pred_valid", int'(bus.pred_valid), 0);
    check_eq("async err", int'(bus.err), 0);
    @(negedge clk);
    rst = 1'b1;
    ldval(5, 1'b0);
    check_eq("idx5 after reset err", int'(bus.err), 1);

    // One-neuron sample, then rst_Cor together with ld_Cor in HOLD
    set_acc(-4);
    ldval(0, 1'b1);
    check_eq("one-neuron pred_valid", int'(bus.pred_valid), 1);
    check_eq("one-neuron pred", int'(bus.pred), 0);
    score(0);
    check_eq("one-neuron correct", int'(bus.correct_cnt), 1);
    check_eq("one-neuron samples", int'(bus.sample_cnt), 1);
    ldval(0, 1'b1);
    bus.ld_Cor = 1'b1; bus.rst_Cor = 1'b1; bus.label = 4'd0;
    step();
    check_eq("rst_Cor correct", int'(bus.correct_cnt), 0);
    check_eq("rst_Cor samples", int'(bus.sample_cnt), 0);
    check_eq("rst_Cor err", int'(bus.err), 0);
    score(0);
    check_eq("post rst_Cor idle err", int'(bus.err), 1);
    check_eq("post rst_Cor samples", int'(bus.sample_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
